// File: rtl/multdiv_iter.sv
// Iterative signed multiply (radix-2 Booth) / divide (non-restoring) unit for the execute stage.
// Optional build macro MULTDIV_EARLY_OUT_EN: trivial operands complete in one cycle.
module multdiv_iter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;
  localparam int unsigned PW    = 2 * WIDTH + 1;
  localparam int unsigned RW    = WIDTH + 2;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MUL  = 2'd1;
  localparam logic [1:0] ST_DIV  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};

  logic [1:0]       state, state_nxt;
  logic [CNT_W-1:0] cnt;

  // Booth datapath: high half is WIDTH+1 bits so adding/subtracting the most-negative multiplicand cannot wrap
  logic [PW-1:0]    prod;
  logic             q_m1;
  logic [WIDTH-1:0] mcand;

  // Non-restoring datapath on magnitudes; sign applied at the end
  logic [RW-1:0]    rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] dsor;
  logic             neg_q;
  logic             div_zero;
  logic             div_ovf;

  logic             start_mul_c, start_div_c, start_c, last_c;
  logic             triv_c, triv_exc_c;
  logic [WIDTH-1:0] abs_a_c, abs_b_c;
  logic [WIDTH:0]   prod_hi_c, mcand_x_c, hi_sum_c;
  logic [PW-1:0]    prod_nxt_c;
  logic [WIDTH:0]   prod_top_c;
  logic             mul_exc_c;
  logic [RW-1:0]    rem_sh_c, dsor_x_c, rem_nxt_c;
  logic [WIDTH-1:0] quo_nxt_c, quo_final_c, div_res_c;
  logic             div_exc_c;

  // Start decode: multiply has priority over divide
  always_comb begin
    start_mul_c = ctrl_MULT;
    start_div_c = ctrl_DIV & ~ctrl_MULT;
    start_c     = ctrl_MULT | ctrl_DIV;
    last_c      = (cnt == CNT_W'(WIDTH - 1));
    abs_a_c     = data_operandA[WIDTH-1] ? WIDTH'(~data_operandA + WIDTH'(1)) : data_operandA;
    abs_b_c     = data_operandB[WIDTH-1] ? WIDTH'(~data_operandB + WIDTH'(1)) : data_operandB;
  end

  always_comb begin
    triv_c     = 1'b0;
    triv_exc_c = 1'b0;
`ifdef MULTDIV_EARLY_OUT_EN
    if (start_mul_c) begin
      triv_c = (data_operandA == '0) || (data_operandB == '0);
    end else if (start_div_c) begin
      triv_c     = (data_operandA == '0) || (data_operandB == '0);
      triv_exc_c = (data_operandB == '0);
    end
`endif
  end

  // One Booth step: add/subtract/skip on the high half, then arithmetic shift right
  always_comb begin
    prod_hi_c = prod[PW-1:WIDTH];
    mcand_x_c = {mcand[WIDTH-1], mcand};
    hi_sum_c  = prod_hi_c;
    case ({prod[0], q_m1})
      2'b01:   hi_sum_c = prod_hi_c + mcand_x_c;
      2'b10:   hi_sum_c = prod_hi_c - mcand_x_c;
      default: hi_sum_c = prod_hi_c;
    endcase
    prod_nxt_c = {hi_sum_c[WIDTH], hi_sum_c, prod[WIDTH-1:1]};
    prod_top_c = prod_nxt_c[2*WIDTH-1:WIDTH-1];
    mul_exc_c  = ~((&prod_top_c) | ~(|prod_top_c));
  end

  // One non-restoring step; quotient bit is set when the new partial remainder is non-negative
  always_comb begin
    rem_sh_c  = {rem[RW-2:0], quo[WIDTH-1]};
    dsor_x_c  = RW'(dsor);
    rem_nxt_c = rem[RW-1] ? (rem_sh_c + dsor_x_c) : (rem_sh_c - dsor_x_c);
    quo_nxt_c = {quo[WIDTH-2:0], ~rem_nxt_c[RW-1]};
    quo_final_c = neg_q ? WIDTH'(~quo_nxt_c + WIDTH'(1)) : quo_nxt_c;
    div_res_c = div_zero ? '0 : quo_final_c;
    div_exc_c = div_zero | div_ovf;
  end

  // Next-state logic; a start overrides every state
  always_comb begin
    state_nxt = state;
    if (start_c) begin
      if (triv_c)           state_nxt = ST_DONE;
      else if (start_mul_c) state_nxt = ST_MUL;
      else                  state_nxt = ST_DIV;
    end else begin
      case (state)
        ST_MUL:  if (last_c) state_nxt = ST_DONE;
        ST_DIV:  if (last_c) state_nxt = ST_DONE;
        ST_DONE: state_nxt = ST_IDLE;
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt            <= '0;
      prod           <= '0;
      q_m1           <= 1'b0;
      mcand          <= '0;
      rem            <= '0;
      quo            <= '0;
      dsor           <= '0;
      neg_q          <= 1'b0;
      div_zero       <= 1'b0;
      div_ovf        <= 1'b0;
      data_result    <= '0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
      busy           <= 1'b0;
    end else begin
      data_resultRDY <= (state_nxt == ST_DONE);
      busy           <= (state_nxt == ST_MUL) || (state_nxt == ST_DIV);
      if (start_c) begin
        cnt      <= '0;
        prod     <= {(WIDTH+1)'(0), data_operandB};
        q_m1     <= 1'b0;
        mcand    <= data_operandA;
        rem      <= '0;
        quo      <= abs_a_c;
        dsor     <= abs_b_c;
        neg_q    <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
        div_zero <= (data_operandB == '0);
        div_ovf  <= (data_operandA == MOST_NEG) && (data_operandB == ALL_ONES);
        if (triv_c) begin
          data_result    <= '0;
          data_exception <= triv_exc_c;
        end
      end else if (state == ST_MUL) begin
        prod <= prod_nxt_c;
        q_m1 <= prod[0];
        cnt  <= cnt + CNT_W'(1);
        if (last_c) begin
          data_result    <= prod_nxt_c[WIDTH-1:0];
          data_exception <= mul_exc_c;
        end
      end else if (state == ST_DIV) begin
        rem <= rem_nxt_c;
        quo <= quo_nxt_c;
        cnt <= cnt + CNT_W'(1);
        if (last_c) begin
          data_result    <= div_res_c;
          data_exception <= div_exc_c;
        end
      end
    end
  end

endmodule

// File: tb/tb_multdiv_iter.sv
// Self-checking bench for multdiv_iter: directed plan cases plus randomized ops against an arithmetic model.
module tb_multdiv_iter;

  localparam int W = 32;
`ifdef MULTDIV_EARLY_OUT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic        clock;
  logic        reset_n;
  logic        ctrl_mult, ctrl_div;
  logic [31:0] op_a, op_b;
  logic [31:0] res;
  logic        exc, rdy, bsy;

  logic        m8, d8;
  logic [7:0]  a8, b8, r8;
  logic        e8, rdy8, bsy8;

  int errors = 0;
  int checks = 0;

  multdiv_iter #(.WIDTH(32)) dut (
    .clock(clock), .reset_n(reset_n), .ctrl_MULT(ctrl_mult), .ctrl_DIV(ctrl_div),
    .data_operandA(op_a), .data_operandB(op_b), .data_result(res),
    .data_exception(exc), .data_resultRDY(rdy), .busy(bsy)
  );

  multdiv_iter #(.WIDTH(8)) dut8 (
    .clock(clock), .reset_n(reset_n), .ctrl_MULT(m8), .ctrl_DIV(d8),
    .data_operandA(a8), .data_operandB(b8), .data_result(r8),
    .data_exception(e8), .data_resultRDY(rdy8), .busy(bsy8)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference: plain signed arithmetic
  function automatic void model(input logic mul, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output logic e);
    longint p;
    int sa, sb;
    logic [31:0] lo;
    sa = a;
    sb = b;
    if (mul) begin
      p  = longint'(sa) * longint'(sb);
      lo = p[31:0];
      r  = lo;
      e  = (p != longint'(int'(lo)));
    end else if (b == 32'd0) begin
      r = 32'd0;
      e = 1'b1;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      r = 32'h8000_0000;
      e = 1'b1;
    end else begin
      r = 32'(sa / sb);
      e = 1'b0;
    end
  endfunction

  function automatic bit trivial(input logic mul, input logic [31:0] a, input logic [31:0] b);
    return EARLY && ((a == 32'd0) || (b == 32'd0));
  endfunction

  // Issue one op and wait (bounded) for its ready pulse; the next call may start during the DONE cycle
  task automatic run_op(input string tag, input logic mul, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] er;
    logic        ee;
    int          exp_lat, got_lat, edge_n;
    bit          busy_bad;
    model(mul, a, b, er, ee);
    exp_lat = trivial(mul, a, b) ? 1 : W + 1;
    @(negedge clock);
    ctrl_mult = mul;
    ctrl_div  = ~mul;
    op_a = a;
    op_b = b;
    @(posedge clock);
    #1;
    edge_n   = 1;
    got_lat  = -1;
    busy_bad = 1'b0;
    if (rdy) got_lat = 1;
    else if (!bsy) busy_bad = 1'b1;
    @(negedge clock);
    ctrl_mult = 1'b0;
    ctrl_div  = 1'b0;
    op_a = $urandom;
    op_b = $urandom;
    while (got_lat < 0 && edge_n < W + 8) begin
      @(posedge clock);
      #1;
      edge_n++;
      if (rdy) got_lat = edge_n;
      else if (!bsy) busy_bad = 1'b1;
    end
    check({tag, "_lat"}, 64'(got_lat), 64'(exp_lat));
    check({tag, "_busy_run"}, 64'(busy_bad), 64'd0);
    check({tag, "_busy_done"}, 64'(bsy), 64'd0);
    check({tag, "_res"}, 64'(res), 64'(er));
    check({tag, "_exc"}, 64'(exc), 64'(ee));
  endtask

  task automatic run8(input string tag, input logic mul, input logic [7:0] a, input logic [7:0] b,
                      input logic [7:0] er, input logic ee);
    int edge_n, got_lat;
    @(negedge clock);
    m8 = mul;
    d8 = ~mul;
    a8 = a;
    b8 = b;
    @(posedge clock);
    #1;
    edge_n  = 1;
    got_lat = rdy8 ? 1 : -1;
    @(negedge clock);
    m8 = 1'b0;
    d8 = 1'b0;
    while (got_lat < 0 && edge_n < 20) begin
      @(posedge clock);
      #1;
      edge_n++;
      if (rdy8) got_lat = edge_n;
    end
    check({tag, "_lat"}, 64'(got_lat), 64'd9);
    check({tag, "_res"}, 64'(r8), 64'(er));
    check({tag, "_exc"}, 64'(e8), 64'(ee));
  endtask

  initial begin
    int          edge_n, first_rdy, rdy_count;
    logic [31:0] ra, rb;
    ctrl_mult = 1'b0; ctrl_div = 1'b0; op_a = '0; op_b = '0;
    m8 = 1'b0; d8 = 1'b0; a8 = '0; b8 = '0;
    reset_n = 1'b1;
    #2 reset_n = 1'b0;
    #1;
    check("rst_res", 64'(res), 64'd0);
    check("rst_exc", 64'(exc), 64'd0);
    check("rst_rdy", 64'(rdy), 64'd0);
    check("rst_busy", 64'(bsy), 64'd0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;

    run_op("mul_7x-6", 1'b1, 32'd7, 32'hFFFF_FFFA);
    @(posedge clock);
    #1;
    check("rdy_one_cycle", 64'(rdy), 64'd0);
    run_op("mul_ovf", 1'b1, 32'h0001_0000, 32'h0001_0000);
    run_op("mul_neg_x1", 1'b1, 32'h8000_0000, 32'd1);
    run_op("mul_neg_sq", 1'b1, 32'h8000_0000, 32'h8000_0000);
    run_op("div_-7_2", 1'b0, 32'hFFFF_FFF9, 32'd2);
    run_op("div_ovf", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op("div_100_7", 1'b0, 32'd100, 32'd7);
    run_op("div_by0", 1'b0, 32'd5, 32'd0);
    run_op("div_0", 1'b0, 32'd0, 32'd9);
    run_op("mul_0", 1'b1, 32'd0, 32'h1234_5678);

    // Abort: MULT 3x3 at edge 1, DIV 9/3 at edge 10 -> single pulse after edge 42
    @(negedge clock);
    ctrl_mult = 1'b1; op_a = 32'd3; op_b = 32'd3;
    @(posedge clock);
    @(negedge clock);
    ctrl_mult = 1'b0;
    edge_n = 1; first_rdy = -1; rdy_count = 0;
    while (edge_n < 60) begin
      if (edge_n == 9) begin
        ctrl_div = 1'b1; op_a = 32'd9; op_b = 32'd3;
      end else begin
        ctrl_div = 1'b0;
      end
      @(posedge clock);
      #1;
      edge_n++;
      if (rdy) begin
        rdy_count++;
        if (first_rdy < 0) first_rdy = edge_n;
      end
      @(negedge clock);
    end
    check("abort_first_rdy", 64'(first_rdy), 64'd42);
    check("abort_rdy_count", 64'(rdy_count), 64'd1);
    check("abort_res", 64'(res), 64'd3);
    check("abort_exc", 64'(exc), 64'd0);

    // Reset mid-operation after edge 15
    @(negedge clock);
    ctrl_mult = 1'b1; op_a = 32'd7; op_b = 32'hFFFF_FFFA;
    @(posedge clock);
    @(negedge clock);
    ctrl_mult = 1'b0;
    repeat (14) @(posedge clock);
    #1;
    check("pre_rst_busy", 64'(bsy), 64'd1);
    reset_n = 1'b0;
    #1;
    check("midrst_res", 64'(res), 64'd0);
    check("midrst_exc", 64'(exc), 64'd0);
    check("midrst_rdy", 64'(rdy), 64'd0);
    check("midrst_busy", 64'(bsy), 64'd0);
    @(negedge clock);
    reset_n = 1'b1;
    rdy_count = 0;
    repeat (40) begin
      @(posedge clock);
      #1;
      if (rdy || bsy) rdy_count++;
    end
    check("midrst_quiet", 64'(rdy_count), 64'd0);

    // Randomized ops, back-to-back and with idle gaps
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 5))
        0: ra = 32'd0;
        1: ra = 32'h8000_0000;
        2: ra = 32'($signed(6'($urandom)));
        default: ra = $urandom;
      endcase
      case ($urandom_range(0, 6))
        0: rb = 32'd0;
        1: rb = 32'hFFFF_FFFF;
        2: rb = 32'($signed(5'($urandom)));
        3: rb = 32'($urandom_range(1, 1000));
        default: rb = $urandom;
      endcase
      run_op("rand", 1'($urandom_range(0, 1)), ra, rb);
      if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 3)) @(posedge clock);
    end

    run8("w8_mul_7x-6", 1'b1, 8'd7, 8'hFA, 8'hD6, 1'b0);
    run8("w8_div_ovf", 1'b0, 8'h80, 8'hFF, 8'h80, 1'b1);
    run8("w8_div_-100_7", 1'b0, 8'h9C, 8'd7, 8'hF2, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
